set_job_feeder: RTL and testbench
=================================

# set_job_feeder

Upstream job feeder for the SET circle-set counting engine. Assembles 6-byte job descriptors from a byte stream and drives the engine's `en`/`central`/`radius`/`mode` inputs. It watches `busy`/`valid`, captures `candidate`, and queues tagged results in a small output FIFO. A watchdog turns a hung job into an error result.

## Interface
- `RES_DEPTH`, default 4: result FIFO depth; power of 2, ≥2.
- `TIMEOUT`, default 255: cycles in WAIT without `valid` before a job is declared failed; 8-bit, >200.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: byte-stream valid.
- `in_data`, input, 8: job byte.
- `in_ready`, output, 1: byte accepted when `in_valid & in_ready` at a rising edge.
- `en`, output, 1: job-start strobe to engine, registered.
- `central`, output, 24: {xA,yA,xB,yB,xC,yC}, 4 bits each, registered.
- `radius`, output, 12: {rA,rB,rC}, registered.
- `mode`, output, 2: engine mode, registered.
- `busy`, input, 1: engine busy.
- `valid`, input, 1: engine result strobe.
- `candidate`, input, 8: engine result, sampled when `valid` is 1.
- `res_valid`, output, 1: FIFO not empty.
- `res_data`, output, 13: {err, tag[3:0], count[7:0]}, FIFO head.
- `res_ready`, input, 1: pop FIFO head when `res_valid & res_ready`.

## Operation
- **Job byte order:**
  - b0: `mode` = `in_data[1:0]`; bits 7:2 ignored.
  - b1: {xA,yA}.
  - b2: {xB,yB}.
  - b3: {xC,yC}.
  - b4: {rA,rB}.
  - b5: {rC, 4'bx}; the low nibble is ignored.
- **Shadow register:** the assembler writes into a shadow register using a byte index 0..5. After b5 is accepted the shadow is full and `in_ready` = 0 until the job is issued. `in_ready` = 1 at all other times.
- **Active register:** drives `central`/`radius`/`mode`. It changes only on issue and holds until the next issue, so `mode` stays stable throughout engine processing.
- **Dispatcher FSM, three states:**
  - IDLE → ISSUE when all of these hold: shadow full, startup done, `busy` = 0, and FIFO count < `RES_DEPTH`. This reserves a FIFO slot for the outstanding result.
  - ISSUE, one cycle: active ← shadow, `en` = 1, shadow freed. Unconditionally → WAIT.
  - WAIT: watchdog counter counts from 0.
    - `valid` = 1: push {0, tag, `candidate`}, tag += 1, → IDLE.
    - Counter reaches `TIMEOUT` with `valid` still 0: push {1, tag, 8'h00}, tag += 1, → IDLE.
    - If `valid` arrives in the same cycle the counter reaches `TIMEOUT`, the `valid` result wins.
- **Startup:** after `rst` deasserts, a 2-cycle startup counter must expire before the first issue, because the engine needs an IDLE→READ_DATA cycle.
- **Stray strobes:** `valid` seen in IDLE or ISSUE is ignored.
- **Tag:** 4-bit job sequence number, 0 after reset, wraps 15 → 0.
- **FIFO:** `RES_DEPTH` entries.
  - Push and pop in the same cycle: both take effect, count unchanged.
  - Pop when empty: ignored.
  - Push when full cannot happen, guaranteed by the issue gate.

## Timing
- **Reset values:**
  - `in_ready` = 1, `en` = 0, `central` = 0, `radius` = 0, `mode` = 0.
  - `res_valid` = 0, `res_data` = 0.
  - Tag = 0, byte index = 0, FIFO empty, FSM = IDLE.
  - Reset mid-job discards partial bytes, the shadow and active jobs, and all queued results.
- **Input:** one byte per cycle at full rate. The shadow may be refilled while a job is in WAIT.
- **Issue timing:** the issue condition is true in cycle t, `en` is high in cycle t+1 for exactly one cycle, and the active outputs are valid from t+1.
  - The freed shadow accepts a new b0 from cycle t+1.
- **Back-to-back jobs:** if the engine's `valid` is sampled in cycle v, the earliest next `en` is cycle v+2.
- **Result latency:** a result pushed at the edge ending cycle v gives `res_valid` = 1 in cycle v+1.
- **Timeout:** a timeout result appears in the FIFO `TIMEOUT`+1 cycles after the `en` cycle.
- **Output registers:** `en` and all engine-facing outputs are registered. `in_ready` and `res_valid` are functions of registers only, with no combinational path from any input.

## Test plan
- **Single job, mode 0:** stream 00,44,00,00,30,00; the engine returns `candidate` = 29. Expect `en` for one cycle, `central` = 24'h440000, `radius` = 12'h300, `mode` = 0, then `res_data` = 13'h01D with tag 0.
- **Back-to-back jobs:** stream job 2 (mode 3) while job 1 is in WAIT. Expect `in_ready` = 0 after job 2's b5, job 2 `en` no earlier than v+2, tags 0 then 1, and `mode` held at 0 until job 2's `en`.
- **Result backpressure:** hold `res_ready` = 0 and stream 5 jobs. Expect exactly 4 issued and the 5th held with `in_ready` = 0. After one pop, the 5th job's `en` follows.
- **Timeout:** the engine model never asserts `valid`, `TIMEOUT` = 255. Expect `res_data` = {1, tag, 8'h00` }` 256 cycles after `en`. A late `valid` afterwards is ignored and the next job issues normally.
- **Reset mid-job:** assert `rst` during WAIT with 2 results queued and 3 bytes of shadow loaded. Expect all outputs at reset values and the FIFO empty. The next full job issues 2 cycles after deassert and is tagged 0.
- **Tag wrap:** run 17 jobs. Expect tags 0..15 then 0 on the 17th result.

Source files
------------

// File: rtl/set_job_feeder_if.sv
// Handshake and engine-facing signal bundle for the SET job feeder.
interface set_job_feeder_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;
  logic        res_valid;
  logic [12:0] res_data;
  logic        res_ready;

  // Byte source, engine and result consumer side.
  modport master (
    output in_valid, in_data, busy, valid, candidate, res_ready,
    input  in_ready, en, central, radius, mode, res_valid, res_data
  );

  // The feeder itself.
  modport slave (
    input  in_valid, in_data, busy, valid, candidate, res_ready,
    output in_ready, en, central, radius, mode, res_valid, res_data
  );
endinterface

// File: rtl/set_job_feeder.sv
// set_job_feeder: assembles 6-byte SET jobs from a byte stream, issues them
// to the counting engine and queues tagged results (or watchdog errors).
//
// state | meaning
// IDLE  | no job outstanding; waiting for a full shadow and a free result slot
// ISSUE | en is high this cycle; active job just loaded from the shadow
// WAIT  | engine working; watchdog running until valid or timeout
module set_job_feeder #(
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input logic             clk,
  input logic             rst,
  set_job_feeder_if.slave bus
);
  localparam int          AW       = $clog2(RES_DEPTH);
  localparam logic [AW:0] FULL_CNT = RES_DEPTH[AW:0];
  localparam logic [7:0]  WD_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  state_t state, state_nxt;

  logic [2:0]  idx;
  logic        shadow_full;
  logic [1:0]  sh_mode;
  logic [23:0] sh_central;
  logic [11:0] sh_radius;
  logic [1:0]  st_cnt;
  logic [7:0]  wd_cnt;
  logic [3:0]  tag;
  logic [12:0] mem [RES_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        en_q;
  logic [23:0] central_q;
  logic [11:0] radius_q;
  logic [1:0]  mode_q;
  logic        accept, issue, push, pop, st_done;
  logic [12:0] push_data;

  assign accept  = bus.in_valid & ~shadow_full;
  assign pop     = bus.res_ready & (count != '0);
  assign st_done = (st_cnt == 2'd0);

  // Dispatcher next state; the issue gate also reserves a result slot.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    push_data = '0;
    case (state)
      IDLE: begin
        if (shadow_full && st_done && !bus.busy && (count < FULL_CNT)) begin
          issue     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.valid) begin
          push      = 1'b1;
          push_data = {1'b0, tag, bus.candidate};
          state_nxt = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          push      = 1'b1;
          push_data = {1'b1, tag, 8'h00};
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Dispatcher state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Byte assembler filling the shadow job; freed on issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= 3'd0;
      shadow_full <= 1'b0;
      sh_mode     <= '0;
      sh_central  <= '0;
      sh_radius   <= '0;
    end else if (issue) begin
      shadow_full <= 1'b0;
    end else if (accept) begin
      case (idx)
        3'd0: sh_mode            <= bus.in_data[1:0];
        3'd1: sh_central[23:16]  <= bus.in_data;
        3'd2: sh_central[15:8]   <= bus.in_data;
        3'd3: sh_central[7:0]    <= bus.in_data;
        3'd4: sh_radius[11:4]    <= bus.in_data;
        3'd5: sh_radius[3:0]     <= bus.in_data[7:4];
        default: ;
      endcase
      if (idx == 3'd5) begin
        idx         <= 3'd0;
        shadow_full <= 1'b1;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Active job and start strobe; held stable between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
    end else begin
      en_q <= issue;
      if (issue) begin
        central_q <= sh_central;
        radius_q  <= sh_radius;
        mode_q    <= sh_mode;
      end
    end
  end

  // Startup delay gives the engine its IDLE->READ_DATA cycle before the first job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          st_cnt <= 2'd2;
    else if (!st_done) st_cnt <= st_cnt - 2'd1;
  end

  // Watchdog counts WAIT cycles; tag advances with every result pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      tag    <= '0;
    end else begin
      if (state == WAIT) wd_cnt <= wd_cnt + 8'd1;
      else               wd_cnt <= '0;
      if (push) tag <= tag + 4'd1;
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Result storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign bus.in_ready  = ~shadow_full;
  assign bus.en        = en_q;
  assign bus.central   = central_q;
  assign bus.radius    = radius_q;
  assign bus.mode      = mode_q;
  assign bus.res_valid = (count != '0);
  assign bus.res_data  = (count != '0) ? mem[rd_ptr] : 13'h0000;
endmodule

// File: tb/tb_set_job_feeder.sv
// Self-checking bench for set_job_feeder: queue-based job/result model plus
// directed scenarios and a randomized soak.
`timescale 1ns/1ps
module tb_set_job_feeder;
  localparam int RES_DEPTH = 4;
  localparam int TIMEOUT   = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  set_job_feeder_if ifc();
  set_job_feeder #(.RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  logic [7:0]  m_sh [6];
  int          m_nb = 0;
  bit          m_out = 0;
  int          m_age = 0;
  int          m_tag = 0;
  int          m_edges = 0;
  logic [12:0] m_fifo [$];
  bit          m_en = 0;
  logic [23:0] m_central = '0;
  logic [11:0] m_radius = '0;
  logic [1:0]  m_mode = '0;

  task automatic model_reset();
    m_nb = 0; m_out = 0; m_age = 0; m_tag = 0; m_edges = 0;
    m_fifo.delete();
    m_en = 0; m_central = '0; m_radius = '0; m_mode = '0;
  endtask

  task automatic model_step();
    bit issue, push, pop;
    logic [12:0] pv;
    pop  = (m_fifo.size() > 0) && ifc.res_ready;
    push = 0;
    pv   = '0;
    if (m_out) begin
      if (m_age >= 1 && ifc.valid) begin push = 1; pv = {1'b0, 4'(m_tag), ifc.candidate}; end
      else if (m_age == TIMEOUT)   begin push = 1; pv = {1'b1, 4'(m_tag), 8'h00}; end
    end
    issue = !m_out && m_nb == 6 && m_edges >= 2 && !ifc.busy && m_fifo.size() < RES_DEPTH;
    if (ifc.in_valid && m_nb < 6) begin m_sh[m_nb] = ifc.in_data; m_nb++; end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      m_fifo.push_back(pv);
      m_tag = (m_tag + 1) % 16;
      m_out = 0;
    end else if (m_out) m_age++;
    m_en = issue;
    if (issue) begin
      m_central = {m_sh[1], m_sh[2], m_sh[3]};
      m_radius  = {m_sh[4], m_sh[5][7:4]};
      m_mode    = m_sh[0][1:0];
      m_nb = 0; m_out = 1; m_age = 0;
    end
    m_edges++;
  endtask

  // Model advances on the same edges as the DUT and resets with it.
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- stimulus state ----------------
  logic [7:0]  byte_q [$];
  logic [12:0] pop_log [$];
  bit   last_ready = 0;
  int   in_pct = 100, pop_pct = 0, stray_pct = 0, busy_pct = 0;
  int   eng_min = 3, eng_max = 3, eng_cnt = 0;
  bit   eng_active = 0, eng_hang = 0, late_valid = 0;
  bit   cand_fixed_en = 0;
  logic [7:0] cand_fixed = 8'h00;
  int   v_cyc = 0, en_count = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    cmp("in_ready",  ifc.in_ready,  32'(m_nb < 6));
    cmp("en",        ifc.en,        32'(m_en));
    cmp("central",   ifc.central,   m_central);
    cmp("radius",    ifc.radius,    m_radius);
    cmp("mode",      ifc.mode,      m_mode);
    cmp("res_valid", ifc.res_valid, 32'(m_fifo.size() != 0));
    cmp("res_data",  ifc.res_data,  (m_fifo.size() != 0) ? m_fifo[0] : 13'h0);
  endtask

  // One cycle: check at the falling edge, then drive the next inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (ifc.in_valid && last_ready && byte_q.size() > 0) void'(byte_q.pop_front());
    check_outputs();
    if (ifc.en === 1'b1) en_count++;
    ifc.valid = 1'b0;
    if (late_valid) begin
      ifc.valid = 1'b1; ifc.candidate = 8'($urandom); late_valid = 0;
    end else if (ifc.en === 1'b1) begin
      eng_active = 1;
      eng_cnt    = int'($urandom_range(eng_max, eng_min));
      ifc.busy   = !eng_hang;
      if ($urandom_range(99) < stray_pct) begin ifc.valid = 1'b1; ifc.candidate = 8'($urandom); end
    end else if (eng_active) begin
      if (eng_hang) ifc.busy = 1'b0;
      else if (eng_cnt <= 1) begin
        ifc.valid     = 1'b1;
        ifc.candidate = cand_fixed_en ? cand_fixed : 8'($urandom);
        ifc.busy      = 1'b0;
        eng_active    = 0;
        v_cyc         = cyc;
      end else begin
        eng_cnt--;
        ifc.busy = 1'b1;
      end
    end else begin
      ifc.busy = ($urandom_range(99) < busy_pct);
      if ($urandom_range(99) < stray_pct) begin ifc.valid = 1'b1; ifc.candidate = 8'($urandom); end
    end
    if (byte_q.size() > 0 && $urandom_range(99) < in_pct) begin
      ifc.in_valid = 1'b1; ifc.in_data = byte_q[0];
    end else begin
      ifc.in_valid = 1'b0; ifc.in_data = 8'($urandom);
    end
    last_ready    = ifc.in_ready;
    ifc.res_ready = ($urandom_range(99) < pop_pct);
    if (ifc.res_valid && ifc.res_ready) pop_log.push_back(ifc.res_data);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst = 1'b1;
    byte_q.delete(); pop_log.delete();
    eng_active = 0; eng_hang = 0; late_valid = 0; last_ready = 0;
    ifc.in_valid = 1'b0; ifc.valid = 1'b0; ifc.busy = 1'b0; ifc.res_ready = 1'b0;
    repeat (hold) step();
    cmp("rst_in_ready",  ifc.in_ready,  1);
    cmp("rst_en",        ifc.en,        0);
    cmp("rst_central",   ifc.central,   0);
    cmp("rst_radius",    ifc.radius,    0);
    cmp("rst_mode",      ifc.mode,      0);
    cmp("rst_res_valid", ifc.res_valid, 0);
    cmp("rst_res_data",  ifc.res_data,  0);
    rst = 1'b0;
    en_count = 0;
  endtask

  task automatic add_job(input logic [7:0] b0, b1, b2, b3, b4, b5);
    byte_q.push_back(b0); byte_q.push_back(b1); byte_q.push_back(b2);
    byte_q.push_back(b3); byte_q.push_back(b4); byte_q.push_back(b5);
  endtask

  task automatic add_rand_job();
    add_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic wait_en(input int maxc, input string nm);
    int k = 0;
    while (ifc.en !== 1'b1 && k < maxc) begin step(); k++; end
    if (ifc.en !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no en within %0d cycles", nm, maxc);
    end
  endtask

  task automatic wait_res(input int maxc, input string nm);
    int k = 0;
    while (ifc.res_valid !== 1'b1 && k < maxc) begin step(); k++; end
    if (ifc.res_valid !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no res_valid within %0d cycles", nm, maxc);
    end
  endtask

  task automatic wait_pops(input int n, input int maxc, input string nm);
    int k = 0;
    while (pop_log.size() < n && k < maxc) begin step(); k++; end
    if (pop_log.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: only %0d results popped, required %0d", nm, pop_log.size(), n);
    end
  endtask

  initial begin
    int e;
    ifc.in_valid = 1'b0; ifc.in_data = 8'h00; ifc.busy = 1'b0; ifc.valid = 1'b0;
    ifc.candidate = 8'h00; ifc.res_ready = 1'b0;

    // Reset state.
    do_reset(3);

    // Single job, mode 0.
    cand_fixed_en = 1; cand_fixed = 8'd29;
    add_job(8'h00, 8'h44, 8'h00, 8'h00, 8'h30, 8'h00);
    wait_en(50, "single_en");
    cmp("single_central", ifc.central, 24'h440000);
    cmp("single_radius",  ifc.radius,  12'h300);
    cmp("single_mode",    ifc.mode,    2'd0);
    step();
    cmp("single_en_pulse", ifc.en, 0);
    wait_res(50, "single_res");
    cmp("single_res_data", ifc.res_data, 13'h01D);

    // Back-to-back jobs.
    do_reset(2);
    eng_min = 20; eng_max = 20;
    add_job(8'h00, 8'h44, 8'h00, 8'h00, 8'h30, 8'h00);
    add_job(8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
    wait_en(50, "b2b_en1");
    repeat (12) step();
    cmp("b2b_in_ready_full", ifc.in_ready, 0);
    cmp("b2b_mode_held",     ifc.mode,     2'd0);
    wait_en(50, "b2b_en2");
    cmp("b2b_gap",     32'(cyc - v_cyc), 2);
    cmp("b2b_mode2",   ifc.mode,    2'd3);
    cmp("b2b_central", ifc.central, 24'h123456);
    cmp("b2b_radius",  ifc.radius,  12'h789);
    pop_pct = 100;
    wait_pops(2, 100, "b2b_pops");
    if (pop_log.size() >= 2) begin
      cmp("b2b_tag0", pop_log[0], 13'h01D);
      cmp("b2b_tag1", pop_log[1][11:8], 1);
    end
    pop_pct = 0;

    // Result backpressure.
    do_reset(2);
    cand_fixed_en = 0;
    eng_min = 3; eng_max = 3;
    repeat (5) add_rand_job();
    repeat (150) step();
    cmp("bp_issued",   en_count, 4);
    cmp("bp_in_ready", ifc.in_ready, 0);
    cmp("bp_res_valid", ifc.res_valid, 1);
    pop_pct = 100; step(); pop_pct = 0;
    wait_en(20, "bp_fifth_en");
    cmp("bp_issued5", en_count, 5);

    // Timeout, then a late valid and a normal job.
    do_reset(2);
    eng_hang = 1;
    add_rand_job();
    wait_en(50, "to_en");
    e = cyc;
    repeat (TIMEOUT) step();
    cmp("to_not_yet", ifc.res_valid, 0);
    step();
    cmp("to_delay",    32'(cyc - e), 256);
    cmp("to_res_valid", ifc.res_valid, 1);
    cmp("to_res_data",  ifc.res_data, 13'h1000);
    eng_hang = 0; eng_active = 0; late_valid = 1;
    step();
    cand_fixed_en = 1; cand_fixed = 8'hA5; eng_min = 4; eng_max = 4;
    add_rand_job();
    pop_pct = 100;
    wait_pops(2, 100, "to_pops");
    if (pop_log.size() >= 2) begin
      cmp("to_pop0", pop_log[0], 13'h1000);
      cmp("to_pop1", pop_log[1], 13'h1A5);
    end
    pop_pct = 0;

    // Reset mid-job.
    do_reset(2);
    eng_min = 3; eng_max = 3;
    add_rand_job(); add_rand_job();
    repeat (40) step();
    cmp("mid_two_queued", 32'(m_fifo.size()), 2);
    eng_min = 100; eng_max = 100;
    add_rand_job();
    byte_q.push_back(8'h01); byte_q.push_back(8'h22); byte_q.push_back(8'h33);
    repeat (15) step();
    cmp("mid_partial_ready", ifc.in_ready, 1);
    do_reset(2);
    cand_fixed = 8'h3C; eng_min = 2; eng_max = 2;
    add_rand_job();
    wait_en(50, "mid_en");
    wait_res(50, "mid_res");
    cmp("mid_tag0", ifc.res_data, 13'h003C);

    // Tag wrap over 17 jobs.
    do_reset(2);
    cand_fixed_en = 0; eng_min = 1; eng_max = 6; pop_pct = 100;
    repeat (17) add_rand_job();
    wait_pops(17, 2000, "wrap_pops");
    if (pop_log.size() >= 17) begin
      cmp("wrap_tag15", pop_log[15][11:8], 15);
      cmp("wrap_tag0",  pop_log[16][11:8], 0);
    end

    // Randomized soak against the model.
    do_reset(2);
    in_pct = 70; pop_pct = 55; stray_pct = 10; busy_pct = 15;
    eng_min = 1; eng_max = 25;
    repeat (40) add_rand_job();
    repeat (1500) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
